// File: rtl/residual_add_if.sv
// Handshake and matrix bus between the residual-add stage and its neighbours.
// The master drives the request and operands; the slave returns the sum.
interface residual_add_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 8,
  parameter int EMB_DIM    = 8,
  parameter int CNT_W      = $clog2(SEQ_LEN*EMB_DIM+1)
);
  localparam int W = DATA_WIDTH*SEQ_LEN*EMB_DIM;

  logic             start;
  logic [W-1:0]     skip_in;
  logic [W-1:0]     sub_in;
  logic [W-1:0]     x_out;
  logic             out_valid;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] sat_count;

  modport master (
    output start, skip_in, sub_in,
    input  x_out, out_valid, done, busy, sat_count
  );

  modport slave (
    input  start, skip_in, sub_in,
    output x_out, out_valid, done, busy, sat_count
  );
endinterface

// File: rtl/residual_add.sv
// Residual connection: skip + sub-layer output, one saturated row per cycle.
// Result matrix and saturation count are published with a done pulse.
module residual_add #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 8,
  parameter int EMB_DIM    = 8,
  parameter int CNT_W      = $clog2(SEQ_LEN*EMB_DIM+1)
) (
  input logic          clk,
  input logic          rst,
  residual_add_if.slave bus
);
  localparam int W     = DATA_WIDTH*SEQ_LEN*EMB_DIM;
  localparam int ROW_W = DATA_WIDTH*EMB_DIM;
  localparam int RW    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  localparam logic [RW-1:0] LAST = RW'(SEQ_LEN-1);
  localparam logic [DATA_WIDTH-1:0] MAXV =
    {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MINV =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [RW-1:0]    row;
  logic [W-1:0]     skip_mem;
  logic [W-1:0]     sub_mem;
  logic [W-1:0]     out_mem;
  logic [W-1:0]     x_q;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] sat_q;
  logic             done_q;

  logic [ROW_W-1:0]   row_sum;
  logic [EMB_DIM-1:0] sat;
  logic [CNT_W-1:0]   row_sat;

  // Overflow of the exact (DATA_WIDTH+1)-bit sum shows as a sign mismatch.
  for (genvar c = 0; c < EMB_DIM; c++) begin : g_lane
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH:0]   s;

    assign a = skip_mem[(int'(row)*EMB_DIM + c)*DATA_WIDTH +: DATA_WIDTH];
    assign b = sub_mem[(int'(row)*EMB_DIM + c)*DATA_WIDTH +: DATA_WIDTH];
    assign s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    assign sat[c] = s[DATA_WIDTH] ^ s[DATA_WIDTH-1];
    assign row_sum[c*DATA_WIDTH +: DATA_WIDTH] =
      !sat[c]        ? s[DATA_WIDTH-1:0] :
      s[DATA_WIDTH]  ? MINV : MAXV;
  end

  always_comb begin
    row_sat = '0;
    for (int c = 0; c < EMB_DIM; c++) begin
      row_sat = row_sat + CNT_W'(sat[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nxt = S_ADD;
      S_ADD:   if (row == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row      <= '0;
      skip_mem <= '0;
      sub_mem  <= '0;
      out_mem  <= '0;
      x_q      <= '0;
      acc      <= '0;
      sat_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            skip_mem <= bus.skip_in;
            sub_mem  <= bus.sub_in;
            row      <= '0;
            acc      <= '0;
          end
        end
        S_ADD: begin
          out_mem[int'(row)*ROW_W +: ROW_W] <= row_sum;
          acc <= acc + row_sat;
          if (row != LAST) row <= row + 1'b1;
        end
        S_DONE: begin
          x_q    <= out_mem;
          sat_q  <= acc;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.x_out     = x_q;
  assign bus.sat_count = sat_q;
  assign bus.done      = done_q;
  assign bus.out_valid = done_q;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_residual_add.sv
// Directed bench for residual_add at default parameters.
// Checks latency, saturation, reset abort and start handling.
module tb_residual_add;
  localparam int DW  = 16;
  localparam int SL  = 8;
  localparam int ED  = 8;
  localparam int CW  = $clog2(SL*ED+1);
  localparam int W   = DW*SL*ED;

  typedef logic [W-1:0] mat_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  residual_add_if #(
    .DATA_WIDTH(DW), .SEQ_LEN(SL), .EMB_DIM(ED), .CNT_W(CW)
  ) bus ();

  residual_add #(
    .DATA_WIDTH(DW), .SEQ_LEN(SL), .EMB_DIM(ED), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic mat_t fill(input logic [15:0] v);
    mat_t m;
    for (int i = 0; i < SL*ED; i++) m[i*DW +: DW] = v;
    return m;
  endfunction

  function automatic mat_t put_row(input mat_t m, input int r,
                                   input logic [15:0] v);
    mat_t o;
    o = m;
    for (int c = 0; c < ED; c++) o[(r*ED+c)*DW +: DW] = v;
    return o;
  endfunction

  function automatic int first_diff(input mat_t a, input mat_t b);
    for (int i = 0; i < SL*ED; i++)
      if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
    return -1;
  endfunction

  // Leaves us at the falling edge after the capture edge (edge 0).
  task automatic launch(input mat_t s, input mat_t u);
    @(negedge clk);
    bus.skip_in = s;
    bus.sub_in  = u;
    bus.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.skip_in = ~s;
    bus.sub_in  = ~u;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.skip_in = fill(16'h1111);
    bus.sub_in  = fill(16'h2222);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.x_out !== '0) begin
      errors++;
      $display("FAIL reset_x_out: got nonzero, expected 0");
    end
    checks++;
    if (bus.sat_count !== '0) begin
      errors++;
      $display("FAIL reset_sat: got %0d, expected 0", bus.sat_count);
    end
    checks++;
    if ({bus.done, bus.out_valid, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 000",
               {bus.done, bus.out_valid, bus.busy});
    end
    rst = 1'b0;
  endtask

  task automatic test_simple;
    mat_t exp;
    int   d;
    exp = fill(16'h0120);
    launch(fill(16'h0100), fill(16'h0020));
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.out_valid} !== 3'b100) begin
        errors++;
        $display("FAIL simple_busy_e%0d: got %b, expected 100", k,
                 {bus.busy, bus.done, bus.out_valid});
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.out_valid} !== 3'b011) begin
      errors++;
      $display("FAIL simple_done: got %b, expected 011",
               {bus.busy, bus.done, bus.out_valid});
    end
    checks++;
    if (bus.x_out !== exp) begin
      errors++;
      d = first_diff(bus.x_out, exp);
      $display("FAIL simple_x_out: elem %0d got %h, expected %h", d,
               bus.x_out[d*DW +: DW], exp[d*DW +: DW]);
    end
    checks++;
    if (bus.sat_count !== CW'(0)) begin
      errors++;
      $display("FAIL simple_sat: got %0d, expected 0", bus.sat_count);
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.out_valid} !== 2'b00 || bus.x_out !== exp) begin
      errors++;
      $display("FAIL simple_pulse: done/valid=%b, expected 00 with x_out held",
               {bus.done, bus.out_valid});
    end
  endtask

  task automatic test_reset_mid;
    mat_t exp;
    int   seen;
    launch(fill(16'h0200), fill(16'h0001));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.x_out !== '0 || bus.sat_count !== '0) begin
      errors++;
      $display("FAIL midrst_state: busy=%b sat=%0d, expected busy 0, all 0",
               bus.busy, bus.sat_count);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_done: got %0d pulses, expected 0", seen);
    end
    exp = fill(16'h0015);
    launch(fill(16'h0010), fill(16'h0005));
    repeat (9) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.x_out !== exp) begin
      errors++;
      $display("FAIL midrst_recover: done=%b, expected 1 with x_out 0015",
               bus.done);
    end
  endtask

  task automatic test_saturation;
    mat_t s, u, exp;
    int   d;
    s   = put_row(put_row(fill(16'h0001), 0, 16'h7F00), 1, 16'h8100);
    u   = put_row(put_row(fill(16'h0001), 0, 16'h0200), 1, 16'hFE00);
    exp = put_row(put_row(fill(16'h0002), 0, 16'h7FFF), 1, 16'h8000);
    launch(s, u);
    repeat (9) @(negedge clk);
    checks++;
    if (bus.x_out !== exp) begin
      errors++;
      d = first_diff(bus.x_out, exp);
      $display("FAIL sat_x_out: elem %0d got %h, expected %h", d,
               bus.x_out[d*DW +: DW], exp[d*DW +: DW]);
    end
    checks++;
    if (bus.sat_count !== CW'(16)) begin
      errors++;
      $display("FAIL sat_count: got %0d, expected 16", bus.sat_count);
    end
  endtask

  task automatic test_mixed;
    mat_t s, u, exp;
    int   d;
    s = put_row(fill(16'h0000), 0, 16'hFFFB);
    s = put_row(s, 1, 16'h7FFF);
    s = put_row(s, 2, 16'h7FFF);
    s = put_row(s, 3, 16'h8000);
    u = put_row(fill(16'h0000), 0, 16'h0003);
    u = put_row(u, 2, 16'h0001);
    exp = put_row(fill(16'h0000), 0, 16'hFFFE);
    exp = put_row(exp, 1, 16'h7FFF);
    exp = put_row(exp, 2, 16'h7FFF);
    exp = put_row(exp, 3, 16'h8000);
    launch(s, u);
    checks++;
    if (bus.sat_count !== CW'(16)) begin
      errors++;
      $display("FAIL mixed_hold_sat: got %0d, expected 16", bus.sat_count);
    end
    repeat (9) @(negedge clk);
    checks++;
    if (bus.x_out !== exp) begin
      errors++;
      d = first_diff(bus.x_out, exp);
      $display("FAIL mixed_x_out: elem %0d got %h, expected %h", d,
               bus.x_out[d*DW +: DW], exp[d*DW +: DW]);
    end
    checks++;
    if (bus.sat_count !== CW'(8)) begin
      errors++;
      $display("FAIL mixed_sat: got %0d, expected 8", bus.sat_count);
    end
  endtask

  task automatic test_back_to_back;
    mat_t ea, eb;
    ea = fill(16'h0003);
    eb = fill(16'h0044);
    launch(fill(16'h0001), fill(16'h0002));
    repeat (3) @(negedge clk);
    bus.skip_in = fill(16'h1000);
    bus.sub_in  = fill(16'h1000);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: got %b, expected 1", bus.busy);
    end
    repeat (4) @(negedge clk);
    bus.skip_in = fill(16'h0040);
    bus.sub_in  = fill(16'h0004);
    bus.start   = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.x_out !== ea) begin
      errors++;
      $display("FAIL b2b_a_done: done=%b, expected 1 with x_out 0003",
               bus.done);
    end
    @(negedge clk);
    bus.start   = 1'b0;
    bus.skip_in = '0;
    bus.sub_in  = '0;
    checks++;
    if ({bus.busy, bus.done} !== 2'b10 || bus.x_out !== ea) begin
      errors++;
      $display("FAIL b2b_b_start: busy/done=%b, expected 10 with A held",
               {bus.busy, bus.done});
    end
    repeat (8) @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.x_out !== ea) begin
      errors++;
      $display("FAIL b2b_a_hold: done=%b, expected 0 with A held",
               bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.x_out !== eb) begin
      errors++;
      $display("FAIL b2b_b_done: done=%b, expected 1 with x_out 0044",
               bus.done);
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_reset_mid();
    test_saturation();
    test_mixed();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
